// File: rtl/hsi_tx_scheduler.sv
// hsi_tx_scheduler: arbitrates SR/CCW/TM/BTC messages onto the single HSI master
// transmitter, holds each grant until done, retransmits on nack or timeout up to
// MAX_RETRY times and enforces GAP_CYCLES idle cycles between messages.
// Build option: define HSI_SCHED_RR_EN for round-robin grant; otherwise fixed
// priority SR > CCW > TM > BTC.
module hsi_tx_scheduler #(
    parameter int unsigned GAP_CYCLES     = 96,
    parameter int unsigned TIMEOUT_CYCLES = 4800,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] ack,
    output logic [3:0] err,
    output logic       tx_start,
    output logic [1:0] tx_sel,
    output logic       tx_repeat,
    input  logic       tx_done,
    input  logic       tx_nack,
    output logic       busy
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [TO_W-1:0] to_cnt, to_n;
    logic [GP_W-1:0] gap_cnt, gap_n;
    logic [RT_W-1:0] retry_cnt, retry_n;
    logic            pend, pend_n;
    logic [1:0]      sel_n;
    logic            start_n, repeat_n, busy_n;
    logic [3:0]      ack_n, err_n;
    logic [1:0]      grant;

`ifdef HSI_SCHED_RR_EN
    logic [1:0] rr_ptr, rr_ptr_n;
    logic [1:0] rr_idx;

    // Round-robin: first requesting source at or after the pointer
    always_comb begin
        grant  = rr_ptr;
        rr_idx = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            rr_idx = rr_ptr + 2'(i);
            if (req[rr_idx]) grant = rr_idx;
        end
    end

    // Pointer advances past each new grant only
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) rr_ptr <= 2'd0;
        else        rr_ptr <= rr_ptr_n;
    end
`else
    // Fixed priority: lowest requesting index wins
    always_comb begin
        grant = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) grant = 2'(i);
        end
    end
`endif

    // Next-state, counters and registered-output next values
    always_comb begin
        state_n  = state;
        to_n     = to_cnt;
        gap_n    = gap_cnt;
        retry_n  = retry_cnt;
        pend_n   = pend;
        sel_n    = tx_sel;
        start_n  = 1'b0;
        repeat_n = 1'b0;
        ack_n    = 4'b0000;
        err_n    = 4'b0000;
`ifdef HSI_SCHED_RR_EN
        rr_ptr_n = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (en && (req != 4'b0000)) begin
                    state_n = START;
                    sel_n   = grant;
                    retry_n = '0;
                    pend_n  = 1'b0;
                    start_n = 1'b1;
`ifdef HSI_SCHED_RR_EN
                    rr_ptr_n = grant + 2'd1;
`endif
                end
            end
            START: begin
                state_n = WAIT;
                to_n    = '0;
            end
            WAIT: begin
                to_n = to_cnt + 1'b1;
                // nack wins over a simultaneous done; timeout counts as nack
                if (tx_nack || (to_cnt == TO_W'(TIMEOUT_CYCLES - 2))) begin
                    if (retry_cnt < RT_W'(MAX_RETRY)) begin
                        retry_n = retry_cnt + 1'b1;
                        pend_n  = 1'b1;
                    end else begin
                        err_n = 4'b0001 << tx_sel;
                    end
                    state_n = GAP;
                    gap_n   = '0;
                end else if (tx_done) begin
                    ack_n   = 4'b0001 << tx_sel;
                    state_n = GAP;
                    gap_n   = '0;
                end
            end
            GAP: begin
                if (gap_cnt == GP_W'(GAP_CYCLES - 1)) begin
                    if (pend) begin
                        state_n  = START;
                        pend_n   = 1'b0;
                        start_n  = 1'b1;
                        repeat_n = (retry_cnt != '0);
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, counters and all outputs registered
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            to_cnt    <= '0;
            gap_cnt   <= '0;
            retry_cnt <= '0;
            pend      <= 1'b0;
            tx_sel    <= 2'd0;
            tx_start  <= 1'b0;
            tx_repeat <= 1'b0;
            ack       <= 4'b0000;
            err       <= 4'b0000;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            to_cnt    <= to_n;
            gap_cnt   <= gap_n;
            retry_cnt <= retry_n;
            pend      <= pend_n;
            tx_sel    <= sel_n;
            tx_start  <= start_n;
            tx_repeat <= repeat_n;
            ack       <= ack_n;
            err       <= err_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_hsi_tx_scheduler.sv
// Bench for hsi_tx_scheduler: directed table, hand-written reset/enable
// sequences and randomized messages checked against a transaction-level model.
module tb_hsi_tx_scheduler;

    localparam int G  = 4;
    localparam int T  = 20;
    localparam int MR = 2;
`ifdef HSI_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Response kinds per attempt: 0 done, 1 nack, 2 done+nack, 3 silence (timeout)
    typedef logic [2:0][1:0] kind_t;
    typedef logic [2:0][7:0] dly_t;
    typedef struct {
        logic [3:0] req;
        kind_t      k;
        dly_t       d;
        int         sel_fp;
        int         sel_rr;
        int         att;
        bit         ok;
        bit         en_drop;
    } vec_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       tx_done = 1'b0;
    logic       tx_nack = 1'b0;
    logic [3:0] ack, err;
    logic       tx_start, tx_repeat, busy;
    logic [1:0] tx_sel;

    int tests = 0;
    int fails = 0;
    int ptr   = 0;
    vec_t tbl [10];

    hsi_tx_scheduler #(
        .GAP_CYCLES    (G),
        .TIMEOUT_CYCLES(T),
        .MAX_RETRY     (MR)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (en),
        .req      (req),
        .ack      (ack),
        .err      (err),
        .tx_start (tx_start),
        .tx_sel   (tx_sel),
        .tx_repeat(tx_repeat),
        .tx_done  (tx_done),
        .tx_nack  (tx_nack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic kind_t mk_k(input int a0, input int a1, input int a2);
        kind_t r;
        r[0] = 2'(a0);
        r[1] = 2'(a1);
        r[2] = 2'(a2);
        return r;
    endfunction

    function automatic dly_t mk_d(input int a0, input int a1, input int a2);
        dly_t r;
        r[0] = 8'(a0);
        r[1] = 8'(a1);
        r[2] = 8'(a2);
        return r;
    endfunction

    // Reference grant: first requester scanning upward from start (start=0 is fixed priority)
    function automatic int model_grant(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return 0;
    endfunction

    // Reference outcome: first plain done ends it; otherwise all MR+1 attempts fail
    function automatic void predict(input kind_t k, output int att, output bit ok);
        ok  = 1'b0;
        att = MR + 1;
        for (int a = MR; a >= 0; a--) begin
            if (k[a] == 2'd0) begin
                att = a + 1;
                ok  = 1'b1;
            end
        end
    endfunction

    // One message from grant to return to idle; called at a negedge with DUT idle
    task automatic do_message(input logic [3:0] reqv, input kind_t k, input dly_t d,
                              input int exp_sel, input int exp_att, input bit exp_ok,
                              input bit en_drop);
        bit         quiet;
        bit         last;
        int         wlen;
        logic [3:0] oh;
        logic [7:0] ev;
        oh  = 4'b0001 << exp_sel;
        req = reqv;
        en  = 1'b1;
        tick();
        check("grant_start", int'(tx_start), 1);
        check("grant_sel", int'(tx_sel), exp_sel);
        check("grant_repeat", int'(tx_repeat), 0);
        check("grant_busy", int'(busy), 1);
        req = 4'b0000;
        if (en_drop) en = 1'b0;
        for (int a = 0; a < exp_att; a++) begin
            quiet = 1'b1;
            wlen  = (k[a] == 2'd3) ? T - 1 : int'(d[a]);
            for (int c = 1; c <= wlen; c++) begin
                tick();
                if (tx_start || ack != 4'b0 || err != 4'b0) quiet = 1'b0;
            end
            check("wait_quiet", int'(quiet), 1);
            tx_done = (k[a] == 2'd0) || (k[a] == 2'd2);
            tx_nack = (k[a] == 2'd1) || (k[a] == 2'd2);
            tick();
            tx_done = 1'b0;
            tx_nack = 1'b0;
            last = (a == exp_att - 1);
            ev   = !last ? 8'h00 : (exp_ok ? {oh, 4'b0000} : {4'b0000, oh});
            check("outcome_ack_err", int'({ack, err}), int'(ev));
            check("outcome_sel", int'(tx_sel), exp_sel);
            // pulses during the gap must be ignored
            if ($urandom_range(0, 1) == 1) begin
                tx_done = 1'b1;
                tx_nack = ($urandom_range(0, 1) == 1);
            end
            quiet = 1'b1;
            for (int c = 1; c < G; c++) begin
                tick();
                tx_done = 1'b0;
                tx_nack = 1'b0;
                if (tx_start || ack != 4'b0 || err != 4'b0 || !busy) quiet = 1'b0;
            end
            tick();
            tx_done = 1'b0;
            tx_nack = 1'b0;
            check("gap_quiet", int'(quiet), 1);
            if (!last) begin
                check("retry_start", int'(tx_start), 1);
                check("retry_repeat", int'(tx_repeat), 1);
                check("retry_sel", int'(tx_sel), exp_sel);
            end else begin
                check("end_idle", int'({busy, tx_start}), 0);
            end
        end
        if (en_drop) begin
            req   = reqv;
            quiet = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (tx_start || busy) quiet = 1'b0;
            end
            check("en_block", int'(quiet), 1);
            req = 4'b0000;
            en  = 1'b1;
        end
    endtask

    initial begin
        int   att;
        bit   ok;
        bit   quiet;
        int   sel;
        logic [3:0] rq;
        kind_t kk;
        dly_t  dd;

        tbl[0] = '{4'b0100, mk_k(0,0,0), mk_d(10,1,1), 2, 2, 1, 1'b1, 1'b0};
        tbl[1] = '{4'b1111, mk_k(0,0,0), mk_d(3,1,1),  0, 3, 1, 1'b1, 1'b0};
        tbl[2] = '{4'b1111, mk_k(0,0,0), mk_d(5,1,1),  0, 0, 1, 1'b1, 1'b0};
        tbl[3] = '{4'b1110, mk_k(0,0,0), mk_d(2,1,1),  1, 1, 1, 1'b1, 1'b0};
        tbl[4] = '{4'b0010, mk_k(1,1,0), mk_d(2,4,6),  1, 1, 3, 1'b1, 1'b1};
        tbl[5] = '{4'b0001, mk_k(3,3,3), mk_d(1,1,1),  0, 0, 3, 1'b0, 1'b0};
        tbl[6] = '{4'b1000, mk_k(2,0,0), mk_d(7,1,1),  3, 3, 2, 1'b1, 1'b0};
        tbl[7] = '{4'b0110, mk_k(1,1,1), mk_d(5,9,18), 1, 1, 3, 1'b0, 1'b1};
        tbl[8] = '{4'b1100, mk_k(3,0,0), mk_d(1,12,1), 2, 2, 2, 1'b1, 1'b0};
        tbl[9] = '{4'b1010, mk_k(0,0,0), mk_d(1,1,1),  1, 3, 1, 1'b1, 1'b0};

        // Reset values
        tick();
        tick();
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_sel", int'(tx_sel), 0);
        check("rst_tx_repeat", int'(tx_repeat), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_err", int'(err), 0);
        n_rst = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_message(tbl[i].req, tbl[i].k, tbl[i].d, RR ? tbl[i].sel_rr : tbl[i].sel_fp,
                       tbl[i].att, tbl[i].ok, tbl[i].en_drop);
        end

        // Request withdrawn while grants are disabled is never served
        en  = 1'b0;
        req = 4'b0001;
        tick();
        tick();
        tick();
        req = 4'b0000;
        en  = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (tx_start || busy) quiet = 1'b0;
        end
        check("dropped_not_served", int'(quiet), 1);

        // Reset mid-WAIT, then fresh grant with early done ignored in START
        req = 4'b0100;
        tick();
        check("rst_mid_start", int'(tx_start), 1);
        tick();
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        check("rst_mid_outputs", int'({ack, err, tx_start, tx_sel, tx_repeat, busy}), 0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        check("rst_regrant_start", int'(tx_start), 1);
        check("rst_regrant_sel", int'(tx_sel), 2);
        check("rst_regrant_repeat", int'(tx_repeat), 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("done_in_start_ignored", int'({ack, err}), 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("rst_regrant_ack", int'(ack), 4);
        req = 4'b0000;
        for (int c = 0; c < G; c++) tick();
        check("rst_regrant_idle", int'(busy), 0);
        ptr = 3;

        // Randomized messages against the reference model
        for (int n = 0; n < 25; n++) begin
            rq  = 4'($urandom_range(1, 15));
            kk  = mk_k(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            dd  = mk_d(int'($urandom_range(1, T - 2)), int'($urandom_range(1, T - 2)), int'($urandom_range(1, T - 2)));
            sel = model_grant(rq, RR ? ptr : 0);
            ptr = (sel + 1) % 4;
            predict(kk, att, ok);
            do_message(rq, kk, dd, sel, att, ok, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
